// File: rtl/mem_access_sequencer_if.sv
// Shared memory-port bundle between the CPU requesters (IF and D), the unified memory
// and the access sequencer. The master side is the environment; the slave side is the sequencer.
interface mem_access_sequencer_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ack;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ack;
   logic [DATA_W-1:0] rd_data;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_wr;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_ack, d_ack, rd_data, mem_addr, mem_wdata, mem_wr
   );

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_ack, d_ack, rd_data, mem_addr, mem_wdata, mem_wr
   );
endinterface

// File: rtl/mem_access_sequencer.sv
// Arbitrates the shared memory port between instruction fetch and data access, one access at a time.
// Define ARB_RR_EN for alternating arbitration on ties; otherwise data always beats fetch.
module mem_access_sequencer #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   mem_access_sequencer_if.slave  bus,
   output logic                   busy,
   output logic [1:0]             state_out
);
   localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t            state_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic              grant_d_reg;
   logic              last_grant_d_reg;
   logic              if_ack_reg;
   logic              d_ack_reg;
   logic [DATA_W-1:0] rd_data_reg;
   logic [ADDR_W-1:0] mem_addr_reg;
   logic [DATA_W-1:0] mem_wdata_reg;
   logic              mem_wr_reg;
   logic              pick_d;

`ifdef ARB_RR_EN
   // On a tie the requester that was not served last time wins.
   assign pick_d = bus.d_req && (!bus.if_req || !last_grant_d_reg);
`else
   logic unused_last_grant;
   assign unused_last_grant = last_grant_d_reg;
   assign pick_d = bus.d_req;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg        <= IDLE;
         cnt_reg          <= '0;
         grant_d_reg      <= 1'b0;
         last_grant_d_reg <= 1'b1;
         if_ack_reg       <= 1'b0;
         d_ack_reg        <= 1'b0;
         rd_data_reg      <= '0;
         mem_addr_reg     <= '0;
         mem_wdata_reg    <= '0;
         mem_wr_reg       <= 1'b0;
      end else begin
         if_ack_reg <= 1'b0;
         d_ack_reg  <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (bus.if_req || bus.d_req) begin
                  grant_d_reg  <= pick_d;
                  mem_addr_reg <= pick_d ? bus.d_addr : bus.if_addr;
                  if (pick_d) begin
                     mem_wdata_reg <= bus.d_wdata;
                  end
                  mem_wr_reg <= pick_d && bus.d_we;
                  cnt_reg    <= CNT_W'(MEM_LATENCY - 1);
                  state_reg  <= ACCESS;
               end else begin
                  mem_wr_reg <= 1'b0;
               end
            end
            ACCESS: begin
               if (cnt_reg == '0) begin
                  // mem_wr is held for the whole access, so it doubles as the read/write flag.
                  if (!mem_wr_reg) begin
                     rd_data_reg <= bus.mem_rdata;
                  end
                  mem_wr_reg <= 1'b0;
                  if_ack_reg <= !grant_d_reg;
                  d_ack_reg  <= grant_d_reg;
                  state_reg  <= DONE;
               end else begin
                  cnt_reg <= cnt_reg - CNT_W'(1);
               end
            end
            DONE: begin
               last_grant_d_reg <= grant_d_reg;
               state_reg        <= IDLE;
            end
            default: begin
               mem_wr_reg <= 1'b0;
               state_reg  <= IDLE;
            end
         endcase
      end
   end

   assign bus.if_ack    = if_ack_reg;
   assign bus.d_ack     = d_ack_reg;
   assign bus.rd_data   = rd_data_reg;
   assign bus.mem_addr  = mem_addr_reg;
   assign bus.mem_wdata = mem_wdata_reg;
   assign bus.mem_wr    = mem_wr_reg;
   assign busy          = (state_reg != IDLE);
   assign state_out     = state_reg;
endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench: requester tasks queue expected acks, a negedge monitor pops and compares.
// Instance u_dut2 runs with MEM_LATENCY=2, u_dut5 with MEM_LATENCY=5.
module tb_mem_access_sequencer;
   localparam int AW = 32;
   localparam int DW = 32;

   logic clock = 1'b0;
   always #5 clock = ~clock;
   logic reset;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   mem_access_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
   mem_access_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
   logic       busy0, busy1;
   logic [1:0] st0, st1;

   mem_access_sequencer #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(2)) u_dut2 (
      .clock(clock), .reset(reset), .bus(bus0.slave), .busy(busy0), .state_out(st0));
   mem_access_sequencer #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(5)) u_dut5 (
      .clock(clock), .reset(reset), .bus(bus1.slave), .busy(busy1), .state_out(st1));

   logic          if_req_v  [2];
   logic [31:0]   if_addr_v [2];
   logic          d_req_v   [2];
   logic          d_we_v    [2];
   logic [31:0]   d_addr_v  [2];
   logic [31:0]   d_wdata_v [2];
   logic          if_ack_w  [2];
   logic          d_ack_w   [2];

   assign bus0.if_req  = if_req_v[0];
   assign bus0.if_addr = if_addr_v[0];
   assign bus0.d_req   = d_req_v[0];
   assign bus0.d_we    = d_we_v[0];
   assign bus0.d_addr  = d_addr_v[0];
   assign bus0.d_wdata = d_wdata_v[0];
   assign bus1.if_req  = if_req_v[1];
   assign bus1.if_addr = if_addr_v[1];
   assign bus1.d_req   = d_req_v[1];
   assign bus1.d_we    = d_we_v[1];
   assign bus1.d_addr  = d_addr_v[1];
   assign bus1.d_wdata = d_wdata_v[1];
   // Memory model: address 0x40 reads back 0xDEADBEEF.
   assign bus0.mem_rdata = bus0.mem_addr ^ 32'hDEADBEAF;
   assign bus1.mem_rdata = bus1.mem_addr ^ 32'hDEADBEAF;
   assign if_ack_w[0] = bus0.if_ack;
   assign if_ack_w[1] = bus1.if_ack;
   assign d_ack_w[0]  = bus0.d_ack;
   assign d_ack_w[1]  = bus1.d_ack;

   typedef struct {
      int          dut;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rd;
      int          ack_cyc;
      int          wr_cycles;
      int          busy_n;
   } exp_t;

   exp_t if_q[$];
   exp_t d_q[$];
   int   busy_run[2];
   int   wr_run[2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic check_ack(input int dut, input bit is_d, input logic [31:0] rd,
                            input logic [31:0] addr, input logic [31:0] wdata);
      exp_t e;
      if ((is_d && d_q.size() == 0) || (!is_d && if_q.size() == 0)) begin
         checks++;
         errors++;
         $display("FAIL unexpected_ack dut=%0d is_d=%0d cycle=%0d actual=ack required=none",
                  dut, is_d, cyc);
         return;
      end
      if (is_d) e = d_q.pop_front();
      else      e = if_q.pop_front();
      $display("ack dut=%0d %s addr=0x%08h rd_data=0x%08h cycle=%0d",
               dut, is_d ? "D " : "IF", addr, rd, cyc);
      chk("ack_dut", dut, e.dut);
      chk("ack_cycle", cyc, e.ack_cyc);
      chk("rd_data", rd, e.rd);
      chk("mem_addr", addr, e.addr);
      chk("busy_cycles", busy_run[dut], e.busy_n);
      chk("mem_wr_cycles", wr_run[dut], e.wr_cycles);
      if (e.wr_cycles != 0) chk("mem_wdata", wdata, e.wdata);
   endtask

   task automatic mon_step(input int dut, input logic ia, input logic da,
                           input logic [31:0] rd, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic wr,
                           input logic [1:0] st, input logic bz);
      if (bz === 1'b1) busy_run[dut]++;
      else begin
         busy_run[dut] = 0;
         wr_run[dut]   = 0;
      end
      if (wr === 1'b1) begin
         wr_run[dut]++;
         chk("mem_wr_outside_access", st, 2'd1);
      end
      if (ia === 1'b1 && da === 1'b1) begin
         checks++;
         errors++;
         $display("FAIL both_acks dut=%0d cycle=%0d actual=2 required=1", dut, cyc);
      end
      if (ia === 1'b1) check_ack(dut, 1'b0, rd, addr, wdata);
      if (da === 1'b1) check_ack(dut, 1'b1, rd, addr, wdata);
   endtask

   always @(negedge clock) begin
      mon_step(0, bus0.if_ack, bus0.d_ack, bus0.rd_data, bus0.mem_addr, bus0.mem_wdata,
               bus0.mem_wr, st0, busy0);
      mon_step(1, bus1.if_ack, bus1.d_ack, bus1.rd_data, bus1.mem_addr, bus1.mem_wdata,
               bus1.mem_wr, st1, busy1);
   end

   task automatic if_access(input int dut, input logic [31:0] addr, input logic [31:0] rd,
                            input int lat, input int busy_n);
      exp_t e;
      bit   got;
      e.dut = dut; e.addr = addr; e.wdata = 32'h0; e.rd = rd;
      e.ack_cyc = cyc + lat; e.wr_cycles = 0; e.busy_n = busy_n;
      if_q.push_back(e);
      if_addr_v[dut] = addr;
      if_req_v[dut]  = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 64 && !got; i++) begin
         @(negedge clock);
         got = if_ack_w[dut];
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL if_ack_timeout dut=%0d actual=no_ack required=ack", dut);
      end
      @(posedge clock);
      #1;
      if_req_v[dut] = 1'b0;
   endtask

   task automatic d_access(input int dut, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rd, input int lat,
                           input int busy_n, input int wr_cycles, input bit scramble);
      exp_t e;
      bit   got;
      e.dut = dut; e.addr = addr; e.wdata = wdata; e.rd = rd;
      e.ack_cyc = cyc + lat; e.wr_cycles = wr_cycles; e.busy_n = busy_n;
      d_q.push_back(e);
      d_we_v[dut]    = we;
      d_addr_v[dut]  = addr;
      d_wdata_v[dut] = wdata;
      d_req_v[dut]   = 1'b1;
      got = 1'b0;
      if (scramble) begin
         // Once granted, changing the requester's inputs must have no effect.
         @(posedge clock);
         #1;
         d_we_v[dut]    = ~we;
         d_addr_v[dut]  = ~addr;
         d_wdata_v[dut] = ~wdata;
      end
      for (int i = 0; i < 64 && !got; i++) begin
         @(negedge clock);
         got = d_ack_w[dut];
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL d_ack_timeout dut=%0d actual=no_ack required=ack", dut);
      end
      @(posedge clock);
      #1;
      d_req_v[dut] = 1'b0;
   endtask

   task automatic chk_cleared(input string tag, input logic ia, input logic da,
                              input logic [31:0] rd, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic wr,
                              input logic bz, input logic [1:0] st);
      chk({tag, "_if_ack"}, ia, 1'b0);
      chk({tag, "_d_ack"}, da, 1'b0);
      chk({tag, "_rd_data"}, rd, 32'h0);
      chk({tag, "_mem_addr"}, addr, 32'h0);
      chk({tag, "_mem_wdata"}, wdata, 32'h0);
      chk({tag, "_mem_wr"}, wr, 1'b0);
      chk({tag, "_busy"}, bz, 1'b0);
      chk({tag, "_state"}, st, 2'd0);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         if_req_v[i] = 1'b0; if_addr_v[i] = 32'h0;
         d_req_v[i] = 1'b0; d_we_v[i] = 1'b0; d_addr_v[i] = 32'h0; d_wdata_v[i] = 32'h0;
      end
      reset = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk_cleared("reset_l2", bus0.if_ack, bus0.d_ack, bus0.rd_data, bus0.mem_addr,
                  bus0.mem_wdata, bus0.mem_wr, busy0, st0);
      chk_cleared("reset_l5", bus1.if_ack, bus1.d_ack, bus1.rd_data, bus1.mem_addr,
                  bus1.mem_wdata, bus1.mem_wr, busy1, st1);
      @(posedge clock);
      #1;
      reset = 1'b0;

      // Single requesters, latency 2: ack 3 cycles after issue, busy 3 cycles.
      if_access(0, 32'h0000_0040, 32'hDEADBEEF, 3, 3);
      d_access(0, 1'b1, 32'h0000_0100, 32'h12345678, 32'hDEADBEEF, 3, 3, 2, 1'b1);
      d_access(0, 1'b0, 32'h0000_0080, 32'h0, 32'hDEADBE2F, 3, 3, 0, 1'b0);

      // Simultaneous requests; the loser waits one full access (4 cycles).
`ifdef ARB_RR_EN
      fork
         if_access(0, 32'h0000_0200, 32'hDEADBCAF, 3, 3);
         d_access(0, 1'b0, 32'h0000_0084, 32'h0, 32'hDEADBE2B, 7, 3, 0, 1'b0);
      join
      fork
         if_access(0, 32'h0000_0044, 32'hDEADBEEB, 3, 3);
         d_access(0, 1'b1, 32'h0000_0104, 32'hCAFEF00D, 32'hDEADBEEB, 7, 3, 2, 1'b0);
      join
`else
      fork
         if_access(0, 32'h0000_0200, 32'hDEADBCAF, 7, 3);
         d_access(0, 1'b0, 32'h0000_0084, 32'h0, 32'hDEADBE2B, 3, 3, 0, 1'b0);
      join
      fork
         if_access(0, 32'h0000_0044, 32'hDEADBEEB, 7, 3);
         d_access(0, 1'b1, 32'h0000_0104, 32'hCAFEF00D, 32'hDEADBCAF, 3, 3, 2, 1'b0);
      join
`endif

      // Reset during the second ACCESS cycle of a store: aborted, no ack.
      d_we_v[0] = 1'b1; d_addr_v[0] = 32'h0000_0300; d_wdata_v[0] = 32'h55AA55AA;
      d_req_v[0] = 1'b1;
      @(posedge clock);
      #1;
      @(posedge clock);
      @(negedge clock);
      chk("abort_pre_mem_wr", bus0.mem_wr, 1'b1);
      chk("abort_pre_state", st0, 2'd1);
      reset = 1'b1;
      d_req_v[0] = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      chk_cleared("abort", bus0.if_ack, bus0.d_ack, bus0.rd_data, bus0.mem_addr,
                  bus0.mem_wdata, bus0.mem_wr, busy0, st0);
      repeat (4) @(posedge clock);
      #1;
      if_access(0, 32'h0000_0048, 32'hDEADBEE7, 3, 3);

      // Latency 5: ack 6 cycles after issue, busy 6 cycles, mem_wr 5 cycles.
      if_access(1, 32'h0000_0040, 32'hDEADBEEF, 6, 6);
      d_access(1, 1'b1, 32'h0000_0010, 32'h0BADF00D, 32'hDEADBEEF, 6, 6, 5, 1'b1);

      repeat (3) @(negedge clock);
      chk("if_queue_drained", if_q.size(), 0);
      chk("d_queue_drained", d_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
